// File: rtl/isq_issue_arbiter.sv
// Two-source issue arbiter feeding one shared execution port. The older op wins,
// the output is registered, and multi-cycle ops hold the port via an occupancy counter.
module isq_issue_arbiter #(
    parameter int DATA_W  = 128,
    parameter int ROBID_W = 7,
    parameter int LAT_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in0_valid,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic [ROBID_W-1:0] in0_robid,
    input  logic [LAT_W-1:0]   in0_lat,
    output logic               in0_ready,
    input  logic               in1_valid,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic [ROBID_W-1:0] in1_robid,
    input  logic [LAT_W-1:0]   in1_lat,
    output logic               in1_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [ROBID_W-1:0] out_robid,
    output logic [LAT_W-1:0]   out_lat,
    output logic               out_src,
    input  logic               out_ready,
    input  logic               flush_valid,
    input  logic [ROBID_W-1:0] flush_robid,
    output logic               port_busy
);

    // Handshake: a transfer happens on any rising edge where valid && ready are both
    // high. Ready never depends on the valid of the same interface's consumer side
    // (it depends only on can_load and the grant), and valid payloads are held while
    // ready stays low.

    logic [LAT_W-1:0] busy_cnt;
    logic             rr;
    logic             can_load;
    logic             tie;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             kill;
    logic             consume;

    // ROB ids carry a wrap bit, so "younger" compares the index in the opposite
    // direction once the two ids sit in different wrap epochs.
    function automatic logic is_younger(input logic [ROBID_W-1:0] a,
                                        input logic [ROBID_W-1:0] b);
        if (a[ROBID_W-1] == b[ROBID_W-1])
            return a[ROBID_W-2:0] > b[ROBID_W-2:0];
        else
            return a[ROBID_W-2:0] < b[ROBID_W-2:0];
    endfunction

    always_comb begin
        tie = in0_valid && in1_valid
              && !is_younger(in0_robid, in1_robid)
              && !is_younger(in1_robid, in0_robid);
        grant0 = in0_valid && (!in1_valid || is_younger(in1_robid, in0_robid) || (tie && !rr));
        grant1 = in1_valid && !grant0;
        // A pipelined op leaving this cycle frees the output register for a new load.
        can_load = !reset && !flush_valid && (busy_cnt == '0)
                   && (!out_valid || (out_ready && (out_lat <= LAT_W'(1))));
        kill    = flush_valid && out_valid && is_younger(out_robid, flush_robid);
        consume = out_valid && out_ready && !kill;
    end

    assign in0_ready = can_load && grant0;
    assign in1_ready = can_load && grant1;
    assign accept    = in0_ready || in1_ready;
    assign port_busy = (busy_cnt != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_robid <= '0;
            out_lat   <= '0;
            out_src   <= 1'b0;
            busy_cnt  <= '0;
            rr        <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= grant1 ? in1_data  : in0_data;
                out_robid <= grant1 ? in1_robid : in0_robid;
                out_lat   <= grant1 ? in1_lat   : in0_lat;
                out_src   <= grant1;
            end else if (kill || consume) begin
                out_valid <= 1'b0;
            end

            // An issued multi-cycle op keeps the port occupied even across a flush.
            if (consume && (out_lat >= LAT_W'(2)))
                busy_cnt <= out_lat - LAT_W'(1);
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - LAT_W'(1);

            if (accept && tie)
                rr <= ~rr;
        end
    end

endmodule

// File: doc/isq_issue_arbiter.md
ISQ_ISSUE_ARBITER -- requirements
Module: isq_issue_arbiter

Interface
REQ-001 Parameter: DATA_W, 128, width of issued micro-op payload.
REQ-002 Parameter: ROBID_W, 7, ROB id width including MSB wrap bit.
REQ-003 Parameter: LAT_W, 4, width of per-op occupancy latency field.
REQ-004 Port: clock  in  1  single clock; all state on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: in0_valid / in1_valid  in  1 each  issue-queue 0/1 (int_isq, mul/div isq) offers an op.
REQ-007 Port: in0_data / in1_data  in  DATA_W each  op payload.
REQ-008 Port: in0_robid / in1_robid  in  ROBID_W each  op ROB id.
REQ-009 Port: in0_lat / in1_lat  in  LAT_W each  cycles the execution port stays occupied (0 and 1 both mean pipelined).
REQ-010 Port: in0_ready / in1_ready  out  1 each  op accepted this cycle when valid&&ready.
REQ-011 Port: out_valid  out  1  registered op presented to shared execution port.
REQ-012 Port: out_data / out_robid / out_lat  out  DATA_W / ROBID_W / LAT_W  registered payload.
REQ-013 Port: out_src  out  1  source queue of registered op (0/1).
REQ-014 Port: out_ready  in  1  execution port consumes out op when out_valid&&out_ready.
REQ-015 Port: flush_valid  in  1  ROB redirect this cycle.
REQ-016 Port: flush_robid  in  ROBID_W  ops strictly younger than this id are killed.
REQ-017 Port: port_busy  out  1  high while occupancy counter is nonzero.

Function
REQ-018 Age compare: A younger than B iff (A.msb==B.msb and A.idx>B.idx) or (A.msb!=B.msb and A.idx<B.idx), idx = low ROBID_W-1 bits.
REQ-019 can_load = !flush_valid && busy_cnt==0 && (!out_valid || (out_ready && out_lat<=1)).
REQ-020 Grant: only in0 valid -> in0; only in1 valid -> in1; both valid -> older robid; equal robids -> round-robin pointer rr (rr=0 favours in0).
REQ-021 inX_ready = can_load && grant==X; at most one ready high per cycle; ready never high when can_load=0.
REQ-022 On accept, out_* loads granted op next edge, out_valid=1, out_src=X; latency in->out exactly 1 cycle.
REQ-023 rr toggles to favour the non-granted source after every tie-broken grant; unchanged otherwise.
REQ-024 On out_valid&&out_ready with no accept same cycle, out_valid clears next edge.
REQ-025 On out_valid&&out_ready with out_lat>=2, busy_cnt loads out_lat-1; busy_cnt decrements by 1 each cycle while nonzero, saturating at 0.
REQ-026 Back-to-back: pipelined op (lat<=1) consumed and new op loaded in same cycle; no bubble.
REQ-027 Flush: if flush_valid and out_valid and out_robid younger than flush_robid, out_valid clears next edge; older/equal op retained; out_ready in a flush cycle still completes transfer of a retained op.
REQ-028 Flush does not clear busy_cnt (already-issued multi-cycle op cannot abort).
REQ-029 port_busy = (busy_cnt!=0); combinational from register.
REQ-030 out_data/out_robid/out_lat/out_src hold value while out_valid=1 and out_ready=0.

Reset
REQ-031 Reset asserted: out_valid=0, out_data=0, out_robid=0, out_lat=0, out_src=0, busy_cnt=0, rr=0, port_busy=0, in0_ready=in1_ready=0 while reset high.
REQ-032 Reset mid-operation discards held op and occupancy immediately; first accept possible on first edge after release.

Verification
REQ-033 Single source: in0 valid robid 5 lat 1, out_ready=1 -> in0_ready=1, next cycle out_valid=1 out_robid=5 out_src=0.
REQ-034 Age: in0 robid 0x41, in1 robid 0x3E same cycle -> in1 granted; with in0 robid 0x02 (wrap) vs in1 0x7E -> in1 granted (older across wrap).
REQ-035 Multi-cycle: in1 lat 4 consumed at cycle T -> port_busy high T+1..T+3, in0_ready low those cycles, in0 accepted cycle T+4.
REQ-036 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, both in*_ready=0.
REQ-037 Flush: out_robid 0x10 held, flush_robid 0x0C -> out_valid=0 next cycle; flush_robid 0x10 -> op retained; in*_ready=0 during flush cycle.
REQ-038 Reset asserted with busy_cnt=3 and out_valid=1 -> all outputs 0 immediately; after release in0 accepted on first edge.
